// File: rtl/regfile_write_demux_if.sv
// Write-port bundle of the register file: write request in; decoded enable, forwarding view
// and flattened register contents out.
interface regfile_write_demux_if #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 4
);
  localparam int NREG = 2 ** ADDR_BITS;

  logic                   wr_en;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [NREG-1:0]        we_onehot;
  logic                   fwd_valid;
  logic [ADDR_BITS-1:0]   fwd_addr;
  logic [WIDTH-1:0]       fwd_data;
  logic [NREG*WIDTH-1:0]  regs_out;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  we_onehot, fwd_valid, fwd_addr, fwd_data, regs_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output we_onehot, fwd_valid, fwd_addr, fwd_data, regs_out
  );
endinterface

// File: rtl/regfile_write_demux.sv
// Register-file write side: one pending stage, one-hot decode, NREG-entry register bank.
// Optional REGFILE_ZERO_REG_EN makes register NREG-1 a hardwired zero register.
module regfile_write_demux #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_demux_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(NREG - 1);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic                  capture_valid;
  logic                  pend_valid;
  logic [ADDR_BITS-1:0]  pend_addr;
  logic [WIDTH-1:0]      pend_data;
  logic [NREG-1:0]       we_onehot;

  // Writes aimed at the zero register are captured as bubbles so they never commit.
  assign capture_valid = bus.wr_en & ~(ZERO_REG & (bus.wr_addr == ZERO_ADDR));

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
  // a blocking write here would let the commit below see this cycle's capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= capture_valid;
      pend_addr  <= bus.wr_addr;
      pend_data  <= bus.wr_data;
    end
  end

  // NOTE: the default comes first, so every path assigns we_onehot and no latch is inferred.
  always_comb begin
    we_onehot = '0;
    if (pend_valid) we_onehot[pend_addr] = 1'b1;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (ZERO_REG && (i == NREG - 1)) begin : g_zero
      assign bus.regs_out[i*WIDTH +: WIDTH] = '0;
    end else begin : g_flop
      logic [WIDTH-1:0] value;

      // NOTE: the bank is flops rather than a RAM macro, so reset can and does clear it.
      always_ff @(posedge clk) begin
        if (reset)             value <= '0;
        else if (we_onehot[i]) value <= pend_data;
      end

      assign bus.regs_out[i*WIDTH +: WIDTH] = value;
    end
  end

  assign bus.we_onehot = we_onehot;
  assign bus.fwd_valid = pend_valid;
  assign bus.fwd_addr  = pend_addr;
  assign bus.fwd_data  = pend_data;
endmodule

// File: tb/tb_regfile_write_demux.sv
// Scoreboard bench for regfile_write_demux: a request log models the register file,
// and a negedge monitor compares every cycle's outputs against the queued expectations.
module tb_regfile_write_demux;
  localparam int WIDTH     = 64;
  localparam int ADDR_BITS = 4;
  localparam int NREG      = 2 ** ADDR_BITS;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic                  valid;
    logic [ADDR_BITS-1:0]  addr;
    logic [WIDTH-1:0]      data;
  } req_t;

  typedef struct packed {
    logic [NREG-1:0]             onehot;
    logic                        valid;
    logic [ADDR_BITS-1:0]        addr;
    logic [WIDTH-1:0]            data;
    logic [NREG-1:0][WIDTH-1:0]  regs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  regfile_write_demux_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

  regfile_write_demux #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  req_t  log_q[$];
  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs after an edge: the newest logged request is the pending one; every
  // older valid request has committed, later writes to an address overriding earlier ones.
  function automatic exp_t expect_after_edge();
    exp_t e;
    req_t cur;
    e = '0;
    if (log_q.size() == 0) return e;
    cur     = log_q[log_q.size()-1];
    e.valid = cur.valid;
    e.addr  = cur.addr;
    e.data  = cur.data;
    e.onehot = cur.valid ? (NREG'(1) << cur.addr) : '0;
    for (int j = 0; j < log_q.size() - 1; j++)
      if (log_q[j].valid) e.regs[log_q[j].addr] = log_q[j].data;
    return e;
  endfunction

  task automatic step(bit rst, bit en, logic [ADDR_BITS-1:0] addr, logic [WIDTH-1:0] data);
    req_t r;
    reset       = rst;
    bus.wr_en   = en;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    if (rst) begin
      log_q.delete();
    end else begin
      r.valid = en && !(ZERO_REG && (addr == ADDR_BITS'(NREG - 1)));
      r.addr  = addr;
      r.data  = data;
      log_q.push_back(r);
    end
    exp_q.push_back(expect_after_edge());
    tag_q.push_back(phase);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: outputs are presented every cycle, so each negedge consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, " we_onehot"}, WIDTH'(bus.we_onehot), WIDTH'(e.onehot));
        check({t, " fwd_valid"}, WIDTH'(bus.fwd_valid), WIDTH'(e.valid));
        check({t, " fwd_addr"},  WIDTH'(bus.fwd_addr),  WIDTH'(e.addr));
        check({t, " fwd_data"},  bus.fwd_data,          e.data);
        for (int i = 0; i < NREG; i++)
          check($sformatf("%s reg%0d", t, i), bus.regs_out[i*WIDTH +: WIDTH], e.regs[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    phase = "reset_idle";
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    idle(5);

    phase = "single_write";
    step(1'b0, 1'b1, 4'd5, 64'hDEAD_BEEF_0123_4567);
    idle(2);

    phase = "back_to_back";
    step(1'b0, 1'b1, 4'd3, 64'h1);
    step(1'b0, 1'b1, 4'd3, 64'h2);
    idle(2);

    phase = "sweep";
    for (int i = 0; i < NREG; i++)
      step(1'b0, 1'b1, ADDR_BITS'(i), WIDTH'(i) * 64'h1111);
    idle(2);

    phase = "reset_mid_op";
    step(1'b0, 1'b1, 4'd9, 64'hFF);
    step(1'b1, 1'b0, '0, '0);
    idle(2);

    phase = "zero_reg";
    step(1'b0, 1'b1, 4'd15, 64'hABCD);
    idle(2);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      bit                   r;
      bit                   en;
      logic [ADDR_BITS-1:0] a;
      r  = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       a = bus.wr_addr;
        1:       a = ADDR_BITS'(NREG - 1);
        default: a = ADDR_BITS'($urandom_range(0, NREG - 1));
      endcase
      step(r, en, a, {$urandom, $urandom});
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("drain", WIDTH'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
